mem_stage_ctrl: RTL and testbench

Parametrised multi-cycle memory stage for the 5-stage ARM pipeline, the successor to the single-cycle data memory. It accepts one load/store per instruction from the EXE/MEM register and services it against an internal word array with a configurable number of wait states. While an access is in flight it raises `freeze` to stall the IF, ID, EXE and MEM pipeline registers. It presents the load result to the MEM/WB register on the release cycle.

---
 rtl/arm_mem_pkg.sv | 30 +++
 rtl/mem_array.sv | 35 +++
 rtl/mem_stage_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the multi-cycle memory stage.
//   - mem_state_e : controller FSM states
//   - DEF_*       : default parameter values
//   - word_index  : byte address -> word index (base subtract, >>2, wrap)
package arm_mem_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_WORDS       = 64;
  localparam int DEF_WAIT_CYCLES = 3;
  localparam int DEF_BASE_ADDR   = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

  // The subtraction is done at 64 bits so that addresses below the base
  // wrap modulo the array size instead of producing a surprise.
  // The caller truncates the result to log2(words) bits.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input int unsigned words);
    logic [63:0] off;
    off = (addr - base) >> 2;
    return off & (64'(words) - 64'd1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage for the memory stage.
//   clk     : clock
//   we_i    : write enable, writes wdata_i to waddr_i on the rising edge
//   waddr_i : write word index
//   wdata_i : write data
//   raddr_i : read word index, sampled on the rising edge
//   rdata_o : registered read data (one cycle after raddr_i)
// Contents and the read register are intentionally not reset.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 64,
  localparam int IDX_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle memory stage controller for the 5-stage pipeline.
// Accepts one load/store in IDLE, spends WAIT_CYCLES cycles in ACCESS while
// stalling the pipeline, then one DONE cycle where the result is presented.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   MEMread    : load request (held while freeze=1)
//   MEMwrite   : store request (held while freeze=1), wins over MEMread
//   address    : byte address
//   data       : store data
//   MEM_result : registered load data, updated only on load completion
//   freeze     : stall to IF/ID/EXE/MEM registers
//   ready      : idle with no request, or access completing (DONE)
module mem_stage_ctrl
  import arm_mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORDS       = DEF_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEMread,
  input  logic              MEMwrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] MEM_result,
  output logic              freeze,
  output logic              ready
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              req;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  assign req     = MEMread | MEMwrite;
  assign req_idx = IDX_W'(word_index(64'(address), 64'(BASE_ADDR), WORDS));

  // The read port is pointed at the incoming index while idle so the word is
  // already registered by the first ACCESS cycle; this keeps WAIT_CYCLES=1
  // working with a synchronous-read array.
  assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    arr_we   = 1'b0;
    freeze   = 1'b0;
    ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          freeze  = 1'b1;
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          is_wr_d = MEMwrite;
          idx_d   = req_idx;
          wdata_d = data;
        end else begin
          ready = 1'b1;
        end
      end
      ACCESS: begin
        freeze = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (is_wr_q) arr_we   = 1'b1;
          else         result_d = arr_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        // Request inputs still belong to the finished instruction here.
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_wr_q  <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS)
  ) u_mem_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (rd_idx),
    .rdata_o (arr_rdata)
  );

  assign MEM_result = result_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

  localparam int WC = 3;

  logic        clk;
  logic        rst;
  logic        MEMread;
  logic        MEMwrite;
  logic [31:0] address;
  logic [31:0] data;
  logic [31:0] MEM_result;
  logic        freeze;
  logic        ready;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;
  logic fz_prev = 1'b0;

  mem_stage_ctrl #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .WORDS       (64),
    .WAIT_CYCLES (WC),
    .BASE_ADDR   (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEMread    (MEMread),
    .MEMwrite   (MEMwrite),
    .address    (address),
    .data       (data),
    .MEM_result (MEM_result),
    .freeze     (freeze),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Count accesses by rising edges of freeze, observed mid-cycle.
  always @(negedge clk) begin
    if (freeze && !fz_prev) n_acc++;
    fz_prev = freeze;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at #1 after a rising edge with the FSM idle. A request is held
  // through freeze and the DONE cycle (unless drop_early), then released.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_res,
                         input string nm, input bit drop_early);
    if (!rd && !wr) begin
      MEMread = 1'b0; MEMwrite = 1'b0; address = a; data = d;
      @(negedge clk);
      chk({nm, " idle freeze"}, 32'(freeze), 32'd0);
      chk({nm, " idle ready"},  32'(ready),  32'd1);
      chk({nm, " idle result"}, MEM_result, exp_res);
      @(posedge clk); #1;
      return;
    end
    MEMread = rd; MEMwrite = wr; address = a; data = d;
    for (int c = 0; c <= WC + 1; c++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d freeze", nm, c), 32'(freeze), 32'(c <= WC));
      chk($sformatf("%s c%0d ready", nm, c),  32'(ready),  32'(c == WC + 1));
      if (c == WC + 1) chk({nm, " result"}, MEM_result, exp_res);
      @(posedge clk); #1;
      if (drop_early && c == 0) begin
        MEMread = 1'b0; MEMwrite = 1'b0; address = 32'h0; data = 32'h0;
      end
    end
    MEMread = 1'b0; MEMwrite = 1'b0;
  endtask

  initial begin
    int t0;
    vecs[0]  = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b0, 32'd0,    32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b1, 32'd1028, 32'h5,        32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h5};
    vecs[6]  = '{1'b0, 1'b1, 32'd1280, 32'h11,       32'h5};
    vecs[7]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'h11};
    vecs[8]  = '{1'b1, 1'b0, 32'd1027, 32'h0,        32'h11};
    vecs[9]  = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h12345678};
    vecs[10] = '{1'b0, 1'b1, 32'd1020, 32'hAA,       32'h12345678};
    vecs[11] = '{1'b1, 1'b0, 32'd1276, 32'h0,        32'hAA};

    rst = 1'b0; MEMread = 1'b0; MEMwrite = 1'b0; address = '0; data = '0;
    repeat (2) @(negedge clk);
    chk("reset freeze", 32'(freeze), 32'd0);
    chk("reset ready",  32'(ready),  32'd1);
    chk("reset result", MEM_result,  32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 12; i++)
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdat,
              vecs[i].exp_res, $sformatf("vec%0d", i), 1'b0);

    // Reset in cycle 2 of a write of 0x22 to word 2: aborted, nothing written.
    MEMread = 1'b0; MEMwrite = 1'b1; address = 32'd1032; data = 32'h22;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; MEMwrite = 1'b0;
    #1;
    chk("rst mid freeze", 32'(freeze), 32'd0);
    chk("rst mid ready",  32'(ready),  32'd1);
    chk("rst mid result", MEM_result,  32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_txn(1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678, "after rst rd", 1'b0);

    // Request dropped during ACCESS still completes with latched values.
    run_txn(1'b0, 1'b1, 32'd1036, 32'h77, 32'h12345678, "drop wr", 1'b1);
    run_txn(1'b1, 1'b0, 32'd1036, 32'h0,  32'h77,       "drop rd", 1'b0);

    // Back-to-back read, write, read.
    t0 = cyc;
    n_acc = 0;
    run_txn(1'b1, 1'b0, 32'd1024, 32'h0,  32'h11, "b2b rd0", 1'b0);
    run_txn(1'b0, 1'b1, 32'd1040, 32'h99, 32'h11, "b2b wr",  1'b0);
    run_txn(1'b1, 1'b0, 32'd1040, 32'h0,  32'h99, "b2b rd1", 1'b0);
    chk("b2b cycles",   32'(cyc - t0), 32'(3 * (WC + 2)));
    chk("b2b accesses", 32'(n_acc),    32'd3);
    run_txn(1'b0, 1'b0, 32'd0, 32'h0, 32'h99, "final idle", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
